// File: rtl/spi_transaction_fsm_pkg.sv
// Shared constants and state type for the SPI transaction controller.
package spi_transaction_fsm_pkg;

  localparam int   ADDR_BITS_DEF = 7;
  localparam int   DATA_BITS_DEF = 8;
  localparam int   CNT_W         = 4;
  localparam logic READ          = 1'b1;

  // Nine states do not fit a 3-bit code, so the register is 4 bits wide.
  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_GET_ADDR     = 4'd1,
    S_DECODE       = 4'd2,
    S_READ_WAIT    = 4'd3,
    S_READ_LOAD    = 4'd4,
    S_READ_SHIFT   = 4'd5,
    S_WRITE_GET    = 4'd6,
    S_WRITE_COMMIT = 4'd7,
    S_DONE         = 4'd8
  } state_t;

  // Header length: address bits plus the trailing R/W bit.
  function automatic int hdr_bits(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/spi_transaction_fsm_edge_counter.sv
// Shared SCLK edge counter. done looks at the value being written this cycle,
// so the FSM can leave a counting state on the same clk as the final edge.
module spi_transaction_fsm_edge_counter
  import spi_transaction_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Clear has priority over the held value; an edge in the clearing cycle still counts.
  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    if (inc) cnt_d = cnt_d + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_d == term);

endmodule

// File: rtl/spi_transaction_fsm.sv
// Control FSM for the SPI memory peripheral: header (address + R/W), then one
// data byte, driving address latch, shift-register load, memory write and MISO enable.
//
// state        | meaning
// IDLE         | waiting for cs_n low
// GET_ADDR     | counting header bits on sclk_pos
// DECODE       | latch address, sample R/W
// READ_WAIT    | memory read latency
// READ_LOAD    | load read data into shift register
// READ_SHIFT   | drive MISO, count sclk_neg
// WRITE_GET    | count data bits on sclk_pos
// WRITE_COMMIT | write data memory
// DONE         | transaction complete, wait for cs_n high
module spi_transaction_fsm
  import spi_transaction_fsm_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_buff_en,
  output logic busy
);

  localparam int HDR_BITS = hdr_bits(ADDR_BITS);

  state_t           state_d;
  state_t           state_q;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_done;

  spi_transaction_fsm_edge_counter u_edge_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (cnt_term),
    .done  (cnt_done)
  );

  // Counter control: clear in the state before each counting state; count only the edge that matters.
  always_comb begin
    cnt_clr  = cs_n || (state_q inside {S_IDLE, S_DECODE, S_READ_LOAD});
    cnt_inc  = 1'b0;
    cnt_term = (state_q == S_GET_ADDR) ? CNT_W'(HDR_BITS) : CNT_W'(DATA_BITS);
    case (state_q)
      S_IDLE, S_GET_ADDR, S_WRITE_GET: cnt_inc = sclk_pos && !cs_n;
      S_READ_SHIFT:                    cnt_inc = sclk_neg && !cs_n;
      default:                         cnt_inc = 1'b0;
    endcase
  end

  // Next-state logic; cs_n high aborts from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (!cs_n) state_d = S_GET_ADDR;
      S_GET_ADDR:     if (cnt_inc && cnt_done) state_d = S_DECODE;
      S_DECODE:       state_d = (rw_bit == READ) ? S_READ_WAIT : S_WRITE_GET;
      S_READ_WAIT:    state_d = S_READ_LOAD;
      S_READ_LOAD:    state_d = S_READ_SHIFT;
      S_READ_SHIFT:   if (cnt_inc && cnt_done) state_d = S_DONE;
      S_WRITE_GET:    if (cnt_inc && cnt_done) state_d = S_WRITE_COMMIT;
      S_WRITE_COMMIT: state_d = S_DONE;
      S_DONE:         state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (cs_n) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Moore output decode from the registered state.
  always_comb begin
    addr_we      = (state_q == S_DECODE);
    sr_we        = (state_q == S_READ_LOAD);
    dm_we        = (state_q == S_WRITE_COMMIT);
    miso_buff_en = (state_q == S_READ_SHIFT);
    busy         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Scoreboard bench for spi_transaction_fsm: stimulus pushes expected events,
// a negedge monitor pops and compares as the DUT produces them.
module tb_spi_transaction_fsm;

  localparam int K_ADDR = 0;
  localparam int K_SR   = 1;
  localparam int K_DM   = 2;
  localparam int K_MISO = 3;
  localparam int K_END  = 4;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic reset, cs_n, sclk_pos, sclk_neg, rw_bit;
  logic addr_we, sr_we, dm_we, miso_buff_en, busy;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  spi_transaction_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .sclk_pos     (sclk_pos),
    .sclk_neg     (sclk_neg),
    .rw_bit       (rw_bit),
    .addr_we      (addr_we),
    .sr_we        (sr_we),
    .dm_we        (dm_we),
    .miso_buff_en (miso_buff_en),
    .busy         (busy)
  );

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "addr_we";
      K_SR:    return "sr_we";
      K_DM:    return "dm_we";
      K_MISO:  return "miso_window";
      default: return "txn_end";
    endcase
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic sb_check(input int k, input int a, input int b, input int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_%s: unexpected event a=%0d b=%0d c=%0d, nothing expected", kname(k), a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        errors++;
        $display("FAIL sb_%s: got %s a=%0d b=%0d c=%0d, expected %s a=%0d b=%0d c=%0d",
                 kname(k), kname(k), a, b, c, kname(e.kind), e.a, e.b, e.c);
      end
    end
  endtask

  // Reference model. Bits are counted as raw SCLK pulses since cs_n fell.
  // Header done after 8 rising edges; write commits after 16 rising edges
  // (plus any spurious ones injected while decoding); read shifts up to
  // 8 falling edges starting with the header's last falling edge.
  task automatic push_expect(input bit rw, input int nbits, input bit spur);
    ev_t e;
    int  na = 0, ns = 0, nd = 0;
    if (nbits >= 8) begin
      e = '{K_ADDR, 8, 7, 0}; exp_q.push_back(e); na = 1;
      if (rw) begin
        e = '{K_SR, 8 + (spur ? 2 : 0), 7, 0}; exp_q.push_back(e); ns = 1;
        e = '{K_MISO, (nbits - 7 < 8) ? nbits - 7 : 8, 0, 0}; exp_q.push_back(e);
      end else if (nbits == 16) begin
        e = '{K_DM, 16 + (spur ? 1 : 0), 15, 0}; exp_q.push_back(e); nd = 1;
      end
    end
    e = '{K_END, na, ns, nd}; exp_q.push_back(e);
  endtask

  task automatic cyc(input bit p, input bit n);
    sclk_pos = p;
    sclk_neg = n;
    @(posedge clk); #1;
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;
  endtask

  // One SCLK bit = rising pulse, 3 idle, falling pulse, 3 idle (8 clk period).
  task automatic send_bits(input logic [7:0] hdr, input int nbits, input bit spur, input bit same);
    cs_n = 1'b0;
    if (!same) cyc(1'b0, 1'b0);
    for (int i = 1; i <= nbits; i++) begin
      rw_bit = (i >= 8) ? hdr[0] : 1'($urandom);
      cyc(1'b1, 1'b0);
      if (i == 8) begin
        cyc(spur, 1'b0);
        cyc(spur && hdr[0], 1'b0);
        cyc(1'b0, 1'b0);
      end else begin
        repeat (3) cyc(1'b0, 1'b0);
      end
      cyc(1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic run_txn(input logic [7:0] hdr, input int nbits, input bit spur,
                         input bit same, input int hold);
    push_expect(hdr[0], nbits, spur);
    send_bits(hdr, nbits, spur, same);
    repeat (2) cyc(1'b0, 1'b0);
    // A finished transaction must ignore edges while cs_n stays low.
    for (int h = 0; h < hold; h++)
      cyc((nbits == 16) && (h % 4 == 0), (nbits == 16) && (h % 4 == 2));
    cs_n = 1'b1;
    cyc(1'b0, 1'b0);
  endtask

  // Monitor state.
  logic p_cs_n = 1'b1, p_busy = 1'b0, p_addr = 1'b0, p_sr = 1'b0, p_dm = 1'b0, p_miso = 1'b0;
  int   pos_cnt = 0, neg_cnt = 0, win_neg = 0, n_a = 0, n_s = 0, n_d = 0;

  always @(negedge clk) begin
    bit start;
    if (mon_en) begin
      if (addr_we || sr_we || dm_we)
        check("strobe_exclusive", $countones({addr_we, sr_we, dm_we}), 1);
      if (p_cs_n && p_busy)
        check("abort_to_idle", int'(busy), 0);
      if (addr_we && !p_addr)    sb_check(K_ADDR, pos_cnt, neg_cnt, 0);
      if (sr_we && !p_sr)        sb_check(K_SR, pos_cnt, neg_cnt, 0);
      if (dm_we && !p_dm)        sb_check(K_DM, pos_cnt, neg_cnt, 0);
      if (!miso_buff_en && p_miso) sb_check(K_MISO, win_neg, 0, 0);
      if (!busy && p_busy)       sb_check(K_END, n_a, n_s, n_d);
    end
    start = !cs_n && p_cs_n;
    pos_cnt <= (start ? 0 : pos_cnt) + int'(sclk_pos);
    neg_cnt <= (start ? 0 : neg_cnt) + int'(sclk_neg);
    win_neg <= (start ? 0 : win_neg) + int'(sclk_neg && miso_buff_en);
    n_a     <= (start ? 0 : n_a) + int'(addr_we);
    n_s     <= (start ? 0 : n_s) + int'(sr_we);
    n_d     <= (start ? 0 : n_d) + int'(dm_we);
    p_cs_n  <= cs_n;
    p_busy  <= busy;
    p_addr  <= addr_we;
    p_sr    <= sr_we;
    p_dm    <= dm_we;
    p_miso  <= miso_buff_en;
  end

  initial begin
    reset = 1'b1; cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", int'({addr_we, sr_we, dm_we, miso_buff_en, busy}), 0);
    reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0);
    check("idle_after_reset", int'(busy), 0);

    // Async reset in the middle of a read data phase.
    send_bits(8'h55, 10, 1'b0, 1'b0);
    check("in_read_shift", int'(miso_buff_en), 1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'({addr_we, sr_we, dm_we, miso_buff_en, busy}), 0);
    cs_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("idle_after_release", int'({addr_we, sr_we, dm_we, miso_buff_en, busy}), 0);

    mon_en = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    run_txn(8'h54, 16, 1'b0, 1'b0, 2);   // write 0x2A
    run_txn(8'h55, 16, 1'b0, 1'b0, 2);   // read 0x2A
    run_txn(8'h54, 13, 1'b0, 1'b0, 0);   // abort after 5 data bits
    run_txn(8'h55, 16, 1'b1, 1'b0, 1);   // spurious edges while decoding
    run_txn(8'h54, 16, 1'b1, 1'b1, 0);   // first edge with cs_n fall
    run_txn(8'hA5, 16, 1'b0, 1'b1, 9);   // back-to-back, long DONE hold
    run_txn(8'hA4, 16, 1'b0, 1'b0, 9);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] hdr;
      int         nb;
      hdr = 8'($urandom);
      nb  = ($urandom_range(0, 1) == 1) ? 16 : $urandom_range(1, 15);
      run_txn(hdr, nb, 1'($urandom), 1'($urandom), $urandom_range(0, 6));
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0);
    end

    repeat (5) cyc(1'b0, 1'b0);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
